// File: rtl/lift_call_scheduler_if.sv
// Target handshake between the call scheduler (master) and the lift motion FSM (slave).
interface lift_call_scheduler_if #(
  parameter int unsigned FLOOR_W = 3
) ();
  logic               tgt_valid;
  logic [FLOOR_W-1:0] tgt_floor;
  logic               tgt_ready;

  modport master (
    output tgt_valid,
    output tgt_floor,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_floor,
    output tgt_ready
  );
endinterface

// File: rtl/lift_call_scheduler.sv
// SCAN-ordered lift call scheduler: latches floor calls, offers one target at a time
// over a valid/ready handshake and supervises each move with a watchdog.
module lift_call_scheduler #(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned FLOOR_W     = 3,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] i_call_req,
  input  logic [FLOOR_W-1:0]    i_cur_floor,
  input  logic                  i_car_arrived,
  lift_call_scheduler_if.master tgt_if,
  output logic                  o_dir_up,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_busy,
  output logic                  o_fault
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {StIdle, StSelect, StIssue, StMoving, StFault} state_e;

  state_e                r_state, w_state_d;
  logic [NUM_FLOORS-1:0] r_pending, w_clr;
  logic                  r_tgt_valid, w_tgt_valid_d;
  logic [FLOOR_W-1:0]    r_tgt_floor, w_tgt_floor_d;
  logic                  r_dir_up, w_dir_up_d;
  logic [WDOG_W-1:0]     r_wdog, w_wdog_d;
  logic                  w_here, w_found_up, w_found_dn;
  logic [FLOOR_W-1:0]    w_up_floor, w_dn_floor;
  logic                  w_at_target;

  // Arrival clear decode; out-of-range cur_floor matches no bit and is ignored.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      w_clr[i] = i_car_arrived && (i_cur_floor == FLOOR_W'(i));
    end
  end

  // Candidate search on registered pending: call here, nearest above, nearest below.
  always_comb begin
    w_here     = 1'b0;
    w_found_up = 1'b0;
    w_found_dn = 1'b0;
    w_up_floor = '0;
    w_dn_floor = '0;
    // Descending scan so the last hit is the lowest floor above.
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (r_pending[i] && (FLOOR_W'(i) > i_cur_floor)) begin
        w_found_up = 1'b1;
        w_up_floor = FLOOR_W'(i);
      end
    end
    // Ascending scan so the last hit is the highest floor below.
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (r_pending[i] && (FLOOR_W'(i) < i_cur_floor)) begin
        w_found_dn = 1'b1;
        w_dn_floor = FLOOR_W'(i);
      end
      if (r_pending[i] && (FLOOR_W'(i) == i_cur_floor)) begin
        w_here = 1'b1;
      end
    end
  end

  assign w_at_target = i_car_arrived && (i_cur_floor == r_tgt_floor);

  // Next-state, target selection and watchdog.
  always_comb begin
    w_state_d     = r_state;
    w_tgt_floor_d = r_tgt_floor;
    w_dir_up_d    = r_dir_up;
    w_wdog_d      = r_wdog;
    unique case (r_state)
      StIdle: begin
        if (|r_pending) w_state_d = StSelect;
      end
      StSelect: begin
        w_state_d = StIssue;
        if (w_here) begin
          w_tgt_floor_d = i_cur_floor;
        end else if (r_dir_up) begin
          if (w_found_up) begin
            w_tgt_floor_d = w_up_floor;
          end else if (w_found_dn) begin
            w_dir_up_d    = 1'b0;
            w_tgt_floor_d = w_dn_floor;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          if (w_found_dn) begin
            w_tgt_floor_d = w_dn_floor;
          end else if (w_found_up) begin
            w_dir_up_d    = 1'b1;
            w_tgt_floor_d = w_up_floor;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StIssue: begin
        if (r_tgt_valid && tgt_if.tgt_ready) begin
          w_state_d = StMoving;
          w_wdog_d  = '0;
        end
      end
      StMoving: begin
        w_wdog_d = r_wdog + 1'b1;
        // Arrival at target beats a simultaneous watchdog expiry.
        if (w_at_target) begin
          w_state_d = StIdle;
        end else if (r_wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
          w_state_d = StFault;
        end
      end
      StFault: begin
        w_state_d = StFault;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    w_tgt_valid_d = (w_state_d == StIssue);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pending   <= '0;
      r_tgt_valid <= 1'b0;
      r_tgt_floor <= '0;
      r_dir_up    <= 1'b1;
      r_wdog      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pending   <= (r_pending | i_call_req) & ~w_clr;
      r_tgt_valid <= w_tgt_valid_d;
      r_tgt_floor <= w_tgt_floor_d;
      r_dir_up    <= w_dir_up_d;
      r_wdog      <= w_wdog_d;
    end
  end

  assign tgt_if.tgt_valid = r_tgt_valid;
  assign tgt_if.tgt_floor = r_tgt_floor;
  assign o_dir_up         = r_dir_up;
  assign o_pending        = r_pending;
  assign o_busy           = (r_state == StSelect) || (r_state == StIssue) || (r_state == StMoving);
  assign o_fault          = (r_state == StFault);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler with a handshake scoreboard.
module tb_lift_call_scheduler;

  localparam int unsigned NF = 8;
  localparam int unsigned FW = 3;
  localparam int unsigned TO = 15;

  typedef struct packed {
    logic [FW-1:0] floor;
    logic          dir;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [NF-1:0] call_req;
  logic [FW-1:0] cur_floor;
  logic          car_arrived;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          busy;
  logic          fault;

  int   total;
  int   bad;
  exp_t q[$];

  lift_call_scheduler_if #(.FLOOR_W(FW)) tgt_if ();

  lift_call_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_call_req   (call_req),
    .i_cur_floor  (cur_floor),
    .i_car_arrived(car_arrived),
    .tgt_if       (tgt_if),
    .o_dir_up     (dir_up),
    .o_pending    (pending),
    .o_busy       (busy),
    .o_fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(tgt_if.tgt_valid), 32'd0);
    check({tag, "_floor"}, 32'(tgt_if.tgt_floor), 32'd0);
    check({tag, "_dir"}, 32'(dir_up), 32'd1);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  // Wait (bounded) for an offered target.
  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!tgt_if.tgt_valid && k < 20) begin
      tick();
      k++;
    end
    if (!tgt_if.tgt_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got no tgt_valid want tgt_valid within 20 cycles", name);
    end
  endtask

  // Accept the offered target, then arrive at floor f one cycle into MOVING.
  task automatic serve(input logic [FW-1:0] f);
    wait_valid("serve_timeout");
    tick();
    cur_floor   = f;
    car_arrived = 1'b1;
    tick();
    car_arrived = 1'b0;
  endtask

  // Scoreboard monitor: every completed handshake pops one expected target.
  always @(negedge clk) begin
    if (!rst && tgt_if.tgt_valid && tgt_if.tgt_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got target %0d want no handshake", tgt_if.tgt_floor);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_floor", 32'(tgt_if.tgt_floor), 32'(e.floor));
        check("sb_dir", 32'(dir_up), 32'(e.dir));
      end
    end
  end

  initial begin
    logic stable;
    logic any_valid;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    call_req    = '0;
    cur_floor   = '0;
    car_arrived = 1'b0;
    tgt_if.tgt_ready = 1'b1;
    tick();
    tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();

    // Single call at floor 5 from floor 0: exact latency.
    q.push_back('{floor: 3'd5, dir: 1'b1});
    call_req = 8'b0010_0000;
    tick();
    call_req = '0;
    check("c1_pending", 32'(pending), 32'h20);
    check("c1_idle", 32'(busy), 32'd0);
    tick();
    check("c2_select_busy", 32'(busy), 32'd1);
    check("c2_select_novalid", 32'(tgt_if.tgt_valid), 32'd0);
    tick();
    check("c3_valid", 32'(tgt_if.tgt_valid), 32'd1);
    check("c3_floor", 32'(tgt_if.tgt_floor), 32'd5);
    tick();
    check("c4_moving_novalid", 32'(tgt_if.tgt_valid), 32'd0);
    cur_floor   = 3'd5;
    car_arrived = 1'b1;
    tick();
    car_arrived = 1'b0;
    check("arr5_pending", 32'(pending), 32'd0);
    check("arr5_idle", 32'(busy), 32'd0);

    // SCAN: from floor 3 going up with calls {1,6}: 6 first, then reverse to 1.
    cur_floor = 3'd3;
    q.push_back('{floor: 3'd6, dir: 1'b1});
    q.push_back('{floor: 3'd1, dir: 1'b0});
    call_req = 8'b0100_0010;
    tick();
    call_req = '0;
    serve(3'd6);
    check("scan_mid_pending", 32'(pending), 32'h02);
    serve(3'd1);
    check("scan_pending", 32'(pending), 32'd0);
    check("scan_dir", 32'(dir_up), 32'd0);

    // Call at the current floor: served in place, direction kept (down).
    cur_floor = 3'd4;
    q.push_back('{floor: 3'd4, dir: 1'b0});
    call_req = 8'b0001_0000;
    tick();
    call_req = '0;
    serve(3'd4);
    check("here_dir", 32'(dir_up), 32'd0);

    // Backpressure: going down with nothing below reverses to 7; hold ready low.
    tgt_if.tgt_ready = 1'b0;
    q.push_back('{floor: 3'd7, dir: 1'b1});
    call_req = 8'b1000_0000;
    tick();
    call_req = '0;
    wait_valid("stall_timeout");
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (tgt_if.tgt_valid !== 1'b1 || tgt_if.tgt_floor !== 3'd7) stable = 1'b0;
      tick();
    end
    check("stall_stable", 32'(stable), 32'd1);
    tgt_if.tgt_ready = 1'b1;
    tick();
    check("stall_release_valid", 32'(tgt_if.tgt_valid), 32'd0);
    check("stall_release_busy", 32'(busy), 32'd1);
    cur_floor   = 3'd7;
    car_arrived = 1'b1;
    tick();
    car_arrived = 1'b0;
    check("stall_done_pending", 32'(pending), 32'd0);

    // Clear beats a simultaneous set at the same floor.
    cur_floor   = 3'd2;
    call_req    = 8'b0000_0100;
    car_arrived = 1'b1;
    tick();
    call_req    = '0;
    car_arrived = 1'b0;
    check("clr_wins_pending", 32'(pending), 32'd0);
    tick();
    check("clr_wins_idle", 32'(busy), 32'd0);

    // Watchdog: no arrival after accepting target 3.
    cur_floor = 3'd0;
    q.push_back('{floor: 3'd3, dir: 1'b1});
    call_req = 8'b0000_1000;
    tick();
    call_req = '0;
    wait_valid("wdog_timeout");
    tick();
    check("wdog_entry_busy", 32'(busy), 32'd1);
    repeat (TO - 1) tick();
    check("wdog_before", 32'(fault), 32'd0);
    tick();
    check("wdog_fault", 32'(fault), 32'd1);
    check("wdog_fault_busy", 32'(busy), 32'd0);
    call_req = 8'b0100_0000;
    tick();
    call_req = '0;
    any_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (tgt_if.tgt_valid !== 1'b0) any_valid = 1'b1;
      tick();
    end
    check("fault_pending", 32'(pending), 32'h48);
    check("fault_no_issue", 32'(any_valid), 32'd0);
    check("fault_sticky", 32'(fault), 32'd1);

    // Asynchronous reset mid-FAULT, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("arst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
